// File: rtl/mitchell_div_seq.sv
// Sequential Mitchell approximate divider: q ~= a / b through log2(a) - log2(b).
// Fixed latency IDLE->LOD->SUB->SHF->DONE with valid/ready on both sides.
module mitchell_div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] q,
    output logic        div0,
    output logic        ovf
);
    typedef enum logic [2:0] {IDLE, LOD, SUB, SHF, DONE} state_t;
    state_t state;

    logic [31:0] a_r;
    logic [15:0] b_r;
    logic [4:0]  ka;
    logic [3:0]  kb;
    logic [15:0] fa, fb;
    logic        za, zb;
    logic [6:0]  e_r;   // two's complement, -16..31
    logic [16:0] m_r;

    function automatic logic [4:0] lod32(input logic [31:0] v);
        lod32 = '0;
        for (int i = 0; i < 32; i++)
            if (v[i]) lod32 = 5'(i);
    endfunction

    function automatic logic [3:0] lod16(input logic [15:0] v);
        lod16 = '0;
        for (int i = 0; i < 16; i++)
            if (v[i]) lod16 = 4'(i);
    endfunction

    logic [4:0]  ka_c;
    logic [3:0]  kb_c;
    logic [31:0] sa;
    logic [15:0] sb;
    logic [16:0] d_c;
    logic [6:0]  e_c;
    logic [4:0]  sh;
    logic [16:0] mq;

    always_comb begin
        ka_c = lod32(a_r);
        kb_c = lod16(b_r);
        // Normalise so the leading one sits at the MSB; the bits below it are the mantissa.
        sa   = a_r << (5'd31 - ka_c);
        sb   = b_r << (4'd15 - kb_c);
        d_c  = {1'b0, fa} - {1'b0, fb};
        e_c  = 7'(ka) - 7'(kb) - 7'(d_c[16]);
        sh   = 5'd16 - {1'b0, e_r[3:0]};
        mq   = m_r >> sh;
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            q         <= '0;
            div0      <= 1'b0;
            ovf       <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            ka        <= '0;
            kb        <= '0;
            fa        <= '0;
            fb        <= '0;
            za        <= 1'b0;
            zb        <= 1'b0;
            e_r       <= '0;
            m_r       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r   <= a;
                    b_r   <= b;
                    state <= LOD;
                end
                LOD: begin
                    ka    <= ka_c;
                    kb    <= kb_c;
                    fa    <= sa[30:15];
                    fb    <= {sb[14:0], 1'b0};
                    za    <= (a_r == '0);
                    zb    <= (b_r == '0);
                    state <= SUB;
                end
                SUB: begin
                    // A mantissa borrow moves one unit from the exponent into 1.f.
                    e_r   <= e_c;
                    m_r   <= {1'b1, d_c[15:0]};
                    state <= SHF;
                end
                SHF: begin
                    div0 <= 1'b0;
                    ovf  <= 1'b0;
                    if (zb) begin
                        q    <= 16'hFFFF;
                        div0 <= 1'b1;
                    end else if (za || e_r[6]) begin
                        q <= '0;
                    end else if (e_r[5:4] != 2'b00) begin
                        q   <= 16'hFFFF;
                        ovf <= 1'b1;
                    end else begin
                        q <= mq[15:0];
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mitchell_div_seq.sv
// Directed bench for mitchell_div_seq: hand-computed quotients, backpressure,
// streaming throughput and mid-operation reset.
module tb_mitchell_div_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;
    logic        div0;
    logic        ovf;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mitchell_div_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .div0(div0), .ovf(ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic div_op(input string tag, input logic [31:0] av, input logic [15:0] bv,
                          input logic [15:0] eq, input logic ed0, input logic eovf);
        int lat;
        in_valid = 1'b1;
        a = av;
        b = bv;
        tick();
        in_valid = 1'b0;
        chk({tag, ".busy"}, 32'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, ".lat"}, 32'(lat), 3);
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".div0"}, 32'(div0), 32'(ed0));
        chk({tag, ".ovf"}, 32'(ovf), 32'(eovf));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".ovdrop"}, 32'(out_valid), 0);
        chk({tag, ".rdy"}, 32'(in_ready), 1);
    endtask

    initial begin
        int lat;
        int first, second;
        logic [15:0] held;
        rst = 1'b1; in_valid = 1'b1; a = 32'd5; b = 16'd1; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst.in_ready", 32'(in_ready), 1);
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.q", 32'(q), 0);
        chk("rst.flags", {30'd0, div0, ovf}, 0);

        div_op("100/10", 32'd100, 16'd10, 16'd10, 1'b0, 1'b0);
        div_op("48/7", 32'd48, 16'd7, 16'd7, 1'b0, 1'b0);
        div_op("1024/4", 32'd1024, 16'd4, 16'd256, 1'b0, 1'b0);
        div_op("65535/1", 32'd65535, 16'd1, 16'hFFFF, 1'b0, 1'b0);
        div_op("0/5", 32'd0, 16'd5, 16'd0, 1'b0, 1'b0);
        div_op("ovf", 32'h0010_0000, 16'd1, 16'hFFFF, 1'b0, 1'b1);
        div_op("3/200", 32'd3, 16'd200, 16'd0, 1'b0, 1'b0);
        div_op("123/0", 32'd123, 16'd0, 16'hFFFF, 1'b1, 1'b0);

        // Backpressure: 100/10 held in DONE while a competing request is offered.
        in_valid = 1'b1; a = 32'd100; b = 16'd10;
        tick();
        a = 32'd7777; b = 16'd3;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp.lat", 32'(lat), 3);
        held = q;
        chk("bp.q", 32'(held), 10);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp.ov_hold", 32'(out_valid), 1);
            chk("bp.q_hold", 32'(q), 10);
            chk("bp.in_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp.ovdrop", 32'(out_valid), 0);
        chk("bp.rdy", 32'(in_ready), 1);
        chk("bp.q_keep", 32'(q), 10);
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid || !in_ready) lat++;
        end
        chk("bp.no_queue", 32'(lat), 0);

        // Streaming with out_ready tied high: results every 5 cycles.
        in_valid = 1'b1; a = 32'd1024; b = 16'd4; out_ready = 1'b1;
        first = -1; second = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        in_valid = 1'b0;
        chk("stream.found", 32'(second >= 0), 1);
        chk("stream.period", 32'(second - first), 5);
        chk("stream.q", 32'(q), 256);
        while (!in_ready) tick();
        out_ready = 1'b0;
        tick();

        // Reset while in SUB: the operation is dropped silently.
        div_op("pre", 32'd123, 16'd0, 16'hFFFF, 1'b1, 1'b0);
        in_valid = 1'b1; a = 32'd100; b = 16'd10;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.ov", 32'(out_valid), 0);
        chk("abort.q", 32'(q), 0);
        chk("abort.flags", {30'd0, div0, ovf}, 0);
        chk("abort.rdy", 32'(in_ready), 1);
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) lat++;
        end
        chk("abort.no_out", 32'(lat), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mitchell_div_seq.md
Name: mitchell_div_seq

Overview:
- Sequential Mitchell (logarithmic) approximate divider. It is the inverse-direction companion to the 16x16->32 ELM_Mitchw2 approximate multiplier.
- Takes a 32-bit dividend and a 16-bit divisor and returns an approximate 16-bit quotient.
- Uses a fixed-latency FSM with valid/ready handshakes on both sides.
- Sits beside the multiplier wrapper so product-domain values can be scaled back down.

Parameters:
- None. Widths are fixed: dividend 32, divisor 16, quotient 16, fraction 16.

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  a/b valid
- in_ready  out  1  block can accept; equals (state==IDLE)
- a  in  32  dividend, unsigned
- b  in  16  divisor, unsigned
- out_valid  out  1  q/div0/ovf valid
- out_ready  in  1  consumer accepts result
- q  out  16  approximate quotient, unsigned
- div0  out  1  b was zero
- ovf  out  1  quotient saturated

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, out_valid=0, q=0, div0=0, ovf=0. Internal operand registers cleared. Reset mid-operation abandons the division and produces no output. in_valid is ignored while rst=1.
- States: IDLE -> LOD -> SUB -> SHF -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid=1 at posedge, capture a,b and go to LOD. Otherwise stay.
- LOD: register leading-one data and zero flags.
  - ka = MSB index of a (0..31).
  - fa = 16 bits immediately below a's leading one, zero-padded.
  - kb = MSB index of b (0..15).
  - fb = 15 bits below b's leading one, zero-padded, then left-aligned to 16 bits.
  - za = (a==0), zb = (b==0).
- SUB: d = {0,fa} - {0,fb} (17-bit). e = ka - kb - (d<0) (signed, range -16..31). m = {1'b1, d[15:0]} (17-bit, value 1.f).
- SHF: compute the result by priority:
  - zb: q=16'hFFFF, div0=1, ovf=0.
  - else za: q=0.
  - else e<0: q=0.
  - else e>=16: q=16'hFFFF, ovf=1.
  - else: q = m >> (16-e), always fits in 16 bits.
  - Then go to DONE.
- DONE: out_valid=1; q/div0/ovf held stable. Leave for IDLE only on the posedge where out_ready=1. out_valid drops the cycle after acceptance. q/flags keep their value until the next SHF.
- Latency: accept edge T; out_valid=1 after edge T+3. Earliest next accept is the edge after out_ready is taken.
  - Back-to-back throughput: one result per 5 cycles with out_ready tied 1.
- in_ready=0 in LOD/SUB/SHF/DONE. in_valid during busy is ignored, not queued.
- out_ready while out_valid=0 is ignored.
- No combinational path from in_valid/out_ready to any output.

Test Plan:
- Reset then a=100, b=10, in_valid 1 cycle -> in_ready low next cycle; out_valid rises 3 cycles after accept; q=10, div0=0, ovf=0.
- a=48, b=7 (fractional borrow path, fa=0x8000, fb=0xC000, e=2) -> q=7 (Mitchell approximation; exact would be 6).
- Exact powers of two: a=1024, b=4 -> q=256. Also a=65535, b=1 -> q=0xFFFF, ovf=0. Also a=0, b=5 -> q=0.
- Boundaries:
  - a=0x00100000, b=1 -> q=0xFFFF, ovf=1.
  - a=3, b=200 (e<0) -> q=0.
  - a=123, b=0 -> q=0xFFFF, div0=1, ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and q stable; in_ready=0; a new in_valid is ignored. Raise out_ready -> out_valid falls next cycle and in_ready rises. With out_ready tied 1, back-to-back stream is accepted every 5 cycles.
- Assert rst during SUB -> next cycle state IDLE, out_valid=0, q=0, flags 0; no result emitted for the aborted operation.
